csr_issue_unit: RTL and testbench

Commit-side initiator for the CSR access interface. It accepts one retired Zicsr instruction at a time from the commit stage and derives the opcode and write-enable. It issues a single-cycle request to the CSR file, waits for the done/exception response, then emits either a register writeback or an illegal-instruction exception. A watchdog converts a missing response into an exception so commit can never hang.

---
 rtl/csr_issue_unit.sv | 129 ++++++++++++
 tb/tb_csr_issue_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_issue_unit.sv
// csr_issue_unit: commit-side initiator for the CSR access interface.
// Takes one retired Zicsr instruction, issues a single-cycle request to the
// CSR file, and returns a writeback or an illegal-instruction exception. A
// watchdog turns a missing response into an exception.
module csr_issue_unit #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_resetn_i,
  input  logic             csr_valid_i,
  output logic             csr_ready_o,
  input  logic [2:0]       csr_funct3_i,
  input  logic [11:0]      csr_address_i,
  input  logic [31:0]      csr_rs1_data_i,
  input  logic [4:0]       csr_uimm_i,
  input  logic             csr_rd_valid_i,
  input  logic [TAG_W-1:0] csr_dest_i,
  output logic             tmu_valid_o,
  output logic [11:0]      tmu_address_o,
  output logic [1:0]       tmu_opcode_o,
  output logic             tmu_wr_en_o,
  output logic [31:0]      tmu_data_o,
  input  logic             tmu_done_i,
  input  logic             tmu_excp_i,
  input  logic [31:0]      tmu_data_i,
  output logic             wb_valid_o,
  output logic [TAG_W-1:0] wb_dest_o,
  output logic [31:0]      wb_data_o,
  output logic             excp_valid_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic             fault;
  logic             rd_valid;
  logic [CNT_W-1:0] cnt;

  logic illegal;
  assign illegal = (csr_funct3_i[1:0] == 2'b00);

  assign csr_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // State register.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) state <= IDLE;
    else               state <= state_next;
  end

  // Next-state selection.
  // An illegal funct3 still passes through ISSUE (with no strobe) so its
  // exception lands two cycles after the handshake; ISSUE then skips WAIT.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (csr_valid_i) state_next = ISSUE;
      ISSUE: state_next = fault ? RESP : WAIT;
      WAIT:  if (tmu_done_i || (cnt == CNT_LAST)) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latching, watchdog, response capture and registered strobes.
  // Strobes are registered on entry to ISSUE/RESP so they coincide with
  // those states.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      tmu_valid_o   <= 1'b0;
      tmu_address_o <= '0;
      tmu_opcode_o  <= '0;
      tmu_wr_en_o   <= 1'b0;
      tmu_data_o    <= '0;
      wb_valid_o    <= 1'b0;
      wb_dest_o     <= '0;
      wb_data_o     <= '0;
      excp_valid_o  <= 1'b0;
      fault         <= 1'b0;
      rd_valid      <= 1'b0;
      cnt           <= '0;
    end else begin
      tmu_valid_o  <= 1'b0;
      wb_valid_o   <= 1'b0;
      excp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (csr_valid_i) begin
            tmu_address_o <= csr_address_i;
            tmu_opcode_o  <= csr_funct3_i[1:0];
            tmu_wr_en_o   <= (csr_funct3_i[1:0] == 2'b01) || (csr_uimm_i != '0);
            tmu_data_o    <= csr_funct3_i[2] ? {27'b0, csr_uimm_i} : csr_rs1_data_i;
            wb_dest_o     <= csr_dest_i;
            rd_valid      <= csr_rd_valid_i;
            fault         <= illegal;
            tmu_valid_o   <= !illegal;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (fault) excp_valid_o <= 1'b1;
        end
        WAIT: begin
          if (tmu_done_i) begin
            fault        <= tmu_excp_i;
            wb_data_o    <= tmu_data_i;
            excp_valid_o <= tmu_excp_i;
            wb_valid_o   <= !tmu_excp_i && rd_valid;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              fault        <= 1'b1;
              excp_valid_o <= 1'b1;
            end
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_issue_unit.sv
// tb_csr_issue_unit: directed vectors for csr_issue_unit with TIMEOUT=4.
module tb_csr_issue_unit;

  localparam int unsigned TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             csr_valid;
  logic             csr_ready;
  logic [2:0]       csr_funct3;
  logic [11:0]      csr_address;
  logic [31:0]      csr_rs1_data;
  logic [4:0]       csr_uimm;
  logic             csr_rd_valid;
  logic [TAG_W-1:0] csr_dest;
  logic             tmu_valid;
  logic [11:0]      tmu_address;
  logic [1:0]       tmu_opcode;
  logic             tmu_wr_en;
  logic [31:0]      tmu_wdata;
  logic             tmu_done;
  logic             tmu_excp;
  logic [31:0]      tmu_rdata;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_dest;
  logic [31:0]      wb_data;
  logic             excp_valid;
  logic             busy;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  int unsigned issue_cnt = 0;
  int unsigned issue_base;
  logic        prev_valid;

  csr_issue_unit #(.TAG_W(TAG_W), .TIMEOUT(4)) dut (
    .cpu_clock_i   (clk),
    .cpu_resetn_i  (rst_n),
    .csr_valid_i   (csr_valid),
    .csr_ready_o   (csr_ready),
    .csr_funct3_i  (csr_funct3),
    .csr_address_i (csr_address),
    .csr_rs1_data_i(csr_rs1_data),
    .csr_uimm_i    (csr_uimm),
    .csr_rd_valid_i(csr_rd_valid),
    .csr_dest_i    (csr_dest),
    .tmu_valid_o   (tmu_valid),
    .tmu_address_o (tmu_address),
    .tmu_opcode_o  (tmu_opcode),
    .tmu_wr_en_o   (tmu_wr_en),
    .tmu_data_o    (tmu_wdata),
    .tmu_done_i    (tmu_done),
    .tmu_excp_i    (tmu_excp),
    .tmu_data_i    (tmu_rdata),
    .wb_valid_o    (wb_valid),
    .wb_dest_o     (wb_dest),
    .wb_data_o     (wb_data),
    .excp_valid_o  (excp_valid),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Count request strobes seen on rising edges.
  always @(posedge clk) if (tmu_valid === 1'b1) issue_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; returns in the ISSUE cycle.
  task automatic offer(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] uimm,
                       input logic rdv, input logic [TAG_W-1:0] tag);
    csr_funct3   = f3;
    csr_address  = addr;
    csr_rs1_data = rs1;
    csr_uimm     = uimm;
    csr_rd_valid = rdv;
    csr_dest     = tag;
    csr_valid    = 1'b1;
    tick();
    csr_valid    = 1'b0;
  endtask

  // From the ISSUE cycle: answer in WAIT, land in RESP.
  task automatic respond(input logic excp, input logic [31:0] data);
    tick();
    tmu_done  = 1'b1;
    tmu_excp  = excp;
    tmu_rdata = data;
    tick();
    tmu_done  = 1'b0;
    tmu_excp  = 1'b0;
    tmu_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    csr_valid = 1'b0; csr_funct3 = 3'b0; csr_address = 12'h0; csr_rs1_data = 32'h0;
    csr_uimm = 5'h0; csr_rd_valid = 1'b0; csr_dest = '0;
    tmu_done = 1'b0; tmu_excp = 1'b0; tmu_rdata = 32'h0;
    tick(); tick();
    check("rst_ready", 32'(csr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmu_valid", 32'(tmu_valid), 32'd0);
    check("rst_wr_en", 32'(tmu_wr_en), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_excp", 32'(excp_valid), 32'd0);
    check("rst_tmu_data", tmu_wdata, 32'h0);
    check("rst_tmu_addr", 32'(tmu_address), 32'h0);
    rst_n = 1'b1;
    tick();

    // CSRRW 0x340
    issue_base = issue_cnt;
    offer(3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 1'b1, 6'd5);
    check("rw_valid", 32'(tmu_valid), 32'd1);
    check("rw_wr_en", 32'(tmu_wr_en), 32'd1);
    check("rw_opcode", 32'(tmu_opcode), 32'd1);
    check("rw_data", tmu_wdata, 32'hDEADBEEF);
    check("rw_addr", 32'(tmu_address), 32'h340);
    check("rw_ready", 32'(csr_ready), 32'd0);
    respond(1'b0, 32'h12345678);
    check("rw_wb_valid", 32'(wb_valid), 32'd1);
    check("rw_wb_dest", 32'(wb_dest), 32'd5);
    check("rw_wb_data", wb_data, 32'h12345678);
    check("rw_excp", 32'(excp_valid), 32'd0);
    tick();
    check("rw_wb_drop", 32'(wb_valid), 32'd0);
    check("rw_ready_back", 32'(csr_ready), 32'd1);
    check("rw_pulses", issue_cnt - issue_base, 32'd1);

    // CSRRS 0xC00, uimm 0 -> read only
    offer(3'b010, 12'hC00, 32'hFFFF0000, 5'd0, 1'b1, 6'd9);
    check("rs_wr_en", 32'(tmu_wr_en), 32'd0);
    check("rs_opcode", 32'(tmu_opcode), 32'd2);
    check("rs_data", tmu_wdata, 32'hFFFF0000);
    respond(1'b0, 32'hA5A5A5A5);
    check("rs_wb_valid", 32'(wb_valid), 32'd1);
    check("rs_wb_dest", 32'(wb_dest), 32'd9);
    check("rs_wb_data", wb_data, 32'hA5A5A5A5);
    tick();

    // CSRRCI 0x300, uimm 0x1F, rd = x0
    offer(3'b111, 12'h300, 32'h55555555, 5'h1F, 1'b0, 6'd3);
    check("rci_opcode", 32'(tmu_opcode), 32'd3);
    check("rci_data", tmu_wdata, 32'h0000001F);
    check("rci_wr_en", 32'(tmu_wr_en), 32'd1);
    check("rci_addr", 32'(tmu_address), 32'h300);
    respond(1'b0, 32'h00000001);
    check("rci_wb_valid", 32'(wb_valid), 32'd0);
    check("rci_excp", 32'(excp_valid), 32'd0);
    tick();

    // Responder fault
    offer(3'b001, 12'h7C0, 32'h1, 5'd0, 1'b1, 6'd2);
    respond(1'b1, 32'hFFFFFFFF);
    check("flt_excp", 32'(excp_valid), 32'd1);
    check("flt_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("flt_excp_drop", 32'(excp_valid), 32'd0);
    check("flt_ready", 32'(csr_ready), 32'd1);

    // Illegal funct3 100: exception at N+2, never issued
    issue_base = issue_cnt;
    offer(3'b100, 12'h340, 32'h1, 5'd1, 1'b1, 6'd7);
    check("ill_valid", 32'(tmu_valid), 32'd0);
    check("ill_excp_n1", 32'(excp_valid), 32'd0);
    tick();
    check("ill_excp_n2", 32'(excp_valid), 32'd1);
    check("ill_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("ill_excp_drop", 32'(excp_valid), 32'd0);
    check("ill_ready", 32'(csr_ready), 32'd1);
    check("ill_pulses", issue_cnt - issue_base, 32'd0);

    // Timeout with TIMEOUT=4: exception 5 cycles after ISSUE
    issue_base = issue_cnt;
    offer(3'b011, 12'h305, 32'h0000000F, 5'd0, 1'b1, 6'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("to_quiet%0d", i), 32'(excp_valid), 32'd0);
    end
    tick();
    check("to_excp", 32'(excp_valid), 32'd1);
    check("to_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("to_ready", 32'(csr_ready), 32'd1);
    check("to_excp_drop", 32'(excp_valid), 32'd0);
    check("to_pulses", issue_cnt - issue_base, 32'd1);

    // Back-to-back with csr_valid held: accepted every 4 cycles
    csr_funct3 = 3'b001; csr_address = 12'h341; csr_rs1_data = 32'h0BADF00D;
    csr_uimm = 5'd0; csr_rd_valid = 1'b1; csr_dest = 6'd12;
    csr_valid = 1'b1;
    prev_valid = 1'b0;
    issue_base = issue_cnt;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("b2b_ready%0d", c), 32'(csr_ready), (c % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_wb%0d", c), 32'(wb_valid), (c % 4 == 3) ? 32'd1 : 32'd0);
      tmu_done   = prev_valid;
      tmu_rdata  = 32'h00000100 + 32'(c);
      prev_valid = tmu_valid;
      if (c == 11) csr_valid = 1'b0;
      tick();
    end
    tmu_done = 1'b0;
    check("b2b_pulses", issue_cnt - issue_base, 32'd3);

    // Reset during WAIT, then a late response
    offer(3'b001, 12'h342, 32'hCAFEF00D, 5'd0, 1'b1, 6'd4);
    tick();
    check("rw_wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(csr_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(tmu_valid), 32'd0);
    check("mid_rst_wb", 32'(wb_valid), 32'd0);
    check("mid_rst_excp", 32'(excp_valid), 32'd0);
    check("mid_rst_data", tmu_wdata, 32'h0);
    rst_n = 1'b1;
    tmu_done = 1'b1; tmu_rdata = 32'h77777777;
    tick();
    tmu_done = 1'b0;
    check("late_wb", 32'(wb_valid), 32'd0);
    check("late_excp", 32'(excp_valid), 32'd0);
    check("late_ready", 32'(csr_ready), 32'd1);
    tick();
    check("late_wb2", 32'(wb_valid), 32'd0);
    check("late_excp2", 32'(excp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
